// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NREQ byte producers. A round-robin
// arbiter picks the next requester in IDLE, latches its byte onto TxData and
// enables the transmitter. After the transmitter reports TxDone, an optional
// inter-frame gap of GAP_TICKS baud ticks runs before the next grant. A tick
// watchdog aborts a frame whose TxDone never arrives and pulses Err.
//
// Ports:
//   Clk      in   system clock
//   Rst_n    in   asynchronous active-low reset
//   Tick     in   baud oversample tick, one Clk wide
//   Req      in   per-requester byte-pending request (level)
//   ReqData  in   requester bytes, byte i at [8i+7:8i]
//   Ack      out  one-hot, one-Clk pulse: byte i accepted
//   Grant    out  one-hot transmitter owner, held through SEND
//   TxData   out  byte presented to the transmitter
//   TxEn     out  transmitter enable, high only in SEND
//   TxDone   in   one-Clk pulse from transmitter at end of stop bit
//   Busy     out  high whenever not IDLE
//   Err      out  one-Clk pulse on watchdog abort
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NREQ          = 4,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 200,
    parameter int CW            = 16
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                Tick,
    input  logic [NREQ-1:0]     Req,
    input  logic [8*NREQ-1:0]   ReqData,
    output logic [NREQ-1:0]     Ack,
    output logic [NREQ-1:0]     Grant,
    output logic [7:0]          TxData,
    output logic                TxEn,
    input  logic                TxDone,
    output logic                Busy,
    output logic                Err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CW-1:0] GAP_TC     = CW'(GAP_TICKS);
    localparam logic [CW-1:0] TIMEOUT_TC = CW'(TIMEOUT_TICKS);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t          state;
    logic [IW-1:0]   last;
    logic [CW-1:0]   count;

    logic [IW-1:0]   scan_idx;
    logic [IW-1:0]   winner;
    logic            found;
    logic [7:0]      win_data;
    logic [NREQ-1:0] win_onehot;

    // Round-robin pick: scan from the requester after the last winner,
    // wrapping around, so the previous winner is checked last.
    always_comb begin
        scan_idx = '0;
        winner   = last;
        found    = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            scan_idx = IW'((int'(last) + i) % NREQ);
            if (!found && Req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // Constant-index decode of the winner into its byte and one-hot vector.
    always_comb begin
        win_data   = 8'h00;
        win_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (winner == IW'(k)) begin
                win_data      = ReqData[8*k +: 8];
                win_onehot[k] = 1'b1;
            end
        end
    end

    // Arbitration FSM with all outputs registered. Ack and Err default low
    // every cycle so that they only ever appear as single-cycle pulses.
    // In SEND, TxDone is checked before the watchdog and before the tick
    // counter, so a coincident TxDone suppresses both the abort and the count.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            last   <= IW'(NREQ - 1);
            count  <= '0;
            Ack    <= '0;
            Grant  <= '0;
            TxData <= 8'h00;
            TxEn   <= 1'b0;
            Busy   <= 1'b0;
            Err    <= 1'b0;
        end else begin
            Ack <= '0;
            Err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        TxData <= win_data;
                        Grant  <= win_onehot;
                        Ack    <= win_onehot;
                        TxEn   <= 1'b1;
                        Busy   <= 1'b1;
                        last   <= winner;
                        count  <= '0;
                        state  <= SEND;
                    end
                end
                SEND: begin
                    if (TxDone || (count >= TIMEOUT_TC)) begin
                        TxEn  <= 1'b0;
                        Grant <= '0;
                        count <= '0;
                        Err   <= !TxDone;
                        if (GAP_TICKS == 0) begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end else if (Tick && (count != CNT_MAX)) begin
                        count <= count + 1'b1;
                    end
                end
                GAP: begin
                    if (count >= GAP_TC) begin
                        count <= '0;
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end else if (Tick && (count != CNT_MAX)) begin
                        count <= count + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Bench for uart_tx_arbiter. Two instances share clock, reset and Tick:
// dut_a uses the default 16-tick gap, dut_b has no gap for back-to-back
// frames. Expected grant/abort events go into a queue per instance and a
// monitor on the falling edge pops and compares whenever Ack or Err fires.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    typedef struct {
        logic       is_err;
        logic [3:0] ack;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        tick;

    logic [3:0]  req_a, req_b;
    logic [31:0] req_data_a, req_data_b;
    logic [3:0]  ack_a, ack_b, grant_a, grant_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        tx_en_a, tx_en_b;
    logic        tx_done_a, tx_done_b;
    logic        busy_a, busy_b;
    logic        err_a, err_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int num_checks = 0;
    int num_errors = 0;

    uart_tx_arbiter #(
        .NREQ(4), .GAP_TICKS(16), .TIMEOUT_TICKS(200), .CW(16)
    ) dut_a (
        .Clk(clk), .Rst_n(rst_n), .Tick(tick),
        .Req(req_a), .ReqData(req_data_a),
        .Ack(ack_a), .Grant(grant_a),
        .TxData(tx_data_a), .TxEn(tx_en_a), .TxDone(tx_done_a),
        .Busy(busy_a), .Err(err_a)
    );

    uart_tx_arbiter #(
        .NREQ(4), .GAP_TICKS(0), .TIMEOUT_TICKS(200), .CW(16)
    ) dut_b (
        .Clk(clk), .Rst_n(rst_n), .Tick(tick),
        .Req(req_b), .ReqData(req_data_b),
        .Ack(ack_b), .Grant(grant_b),
        .TxData(tx_data_b), .TxEn(tx_en_b), .TxDone(tx_done_b),
        .Busy(busy_b), .Err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and keep the running totals.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Each tick is one Clk high followed by one Clk low.
    task automatic pulseTicks(input int n);
        repeat (n) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(1);
        end
    endtask

    task automatic applyStimulus(input bit inst_b, input logic [3:0] req,
                                 input logic [31:0] data);
        if (inst_b) begin
            req_b      = req;
            req_data_b = data;
        end else begin
            req_a      = req;
            req_data_a = data;
        end
    endtask

    task automatic expectGrant(input bit inst_b, input logic [3:0] ack,
                               input logic [7:0] data);
        exp_t e;
        e.is_err = 1'b0;
        e.ack    = ack;
        e.data   = data;
        if (inst_b) q_b.push_back(e);
        else        q_a.push_back(e);
    endtask

    task automatic expectErrA();
        exp_t e;
        e.is_err = 1'b1;
        e.ack    = 4'b0000;
        e.data   = 8'h00;
        q_a.push_back(e);
    endtask

    // End a frame on dut_a with TxDone, then run out the gap.
    task automatic finishFrameA(input string tag);
        tx_done_a = 1'b1;
        step(1);
        tx_done_a = 1'b0;
        checkOutput({tag, "_txen_off"}, 32'(tx_en_a), 32'h0);
        checkOutput({tag, "_grant_off"}, 32'(grant_a), 32'h0);
        pulseTicks(16);
        checkOutput({tag, "_idle"}, 32'(busy_a), 32'h0);
    endtask

    // Scoreboard monitor for dut_a.
    always @(negedge clk) begin
        if (rst_n && ((ack_a != 4'b0000) || err_a)) begin
            if (q_a.size() == 0) begin
                num_checks++;
                num_errors++;
                $display("[TB] FAIL mon_a_unexpected: ack=%b err=%b data=%h, expected no event",
                         ack_a, err_a, tx_data_a);
            end else begin
                e_a = q_a.pop_front();
                checkOutput("mon_a_err", 32'(err_a), 32'(e_a.is_err));
                checkOutput("mon_a_ack", 32'(ack_a), 32'(e_a.ack));
                checkOutput("mon_a_grant", 32'(grant_a), 32'(e_a.ack));
                if (!e_a.is_err)
                    checkOutput("mon_a_data", 32'(tx_data_a), 32'(e_a.data));
            end
        end
    end

    // Scoreboard monitor for dut_b.
    always @(negedge clk) begin
        if (rst_n && ((ack_b != 4'b0000) || err_b)) begin
            if (q_b.size() == 0) begin
                num_checks++;
                num_errors++;
                $display("[TB] FAIL mon_b_unexpected: ack=%b err=%b data=%h, expected no event",
                         ack_b, err_b, tx_data_b);
            end else begin
                e_b = q_b.pop_front();
                checkOutput("mon_b_err", 32'(err_b), 32'(e_b.is_err));
                checkOutput("mon_b_ack", 32'(ack_b), 32'(e_b.ack));
                checkOutput("mon_b_grant", 32'(grant_b), 32'(e_b.ack));
                if (!e_b.is_err)
                    checkOutput("mon_b_data", 32'(tx_data_b), 32'(e_b.data));
            end
        end
    end

    // Hard stop in case the run ever wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        tick       = 1'b0;
        req_a      = 4'b0000;
        req_b      = 4'b0000;
        req_data_a = 32'h0;
        req_data_b = 32'h0;
        tx_done_a  = 1'b0;
        tx_done_b  = 1'b0;

        // Reset state.
        step(2);
        checkOutput("rst_ack", 32'(ack_a), 32'h0);
        checkOutput("rst_grant", 32'(grant_a), 32'h0);
        checkOutput("rst_txdata", 32'(tx_data_a), 32'h0);
        checkOutput("rst_txen", 32'(tx_en_a), 32'h0);
        checkOutput("rst_busy", 32'(busy_a), 32'h0);
        checkOutput("rst_err", 32'(err_a), 32'h0);
        rst_n = 1'b1;
        step(1);

        // Back-to-back round robin on the no-gap instance: 0,1,2,3,0.
        applyStimulus(1'b1, 4'b1111, 32'h44332211);
        expectGrant(1'b1, 4'b0001, 8'h11);
        for (int k = 0; k < 5; k++) begin
            step(1);
            checkOutput("b2b_txen_on", 32'(tx_en_b), 32'h1);
            checkOutput("b2b_grant", 32'(grant_b), 32'h1 << (k % 4));
            if (k == 4) applyStimulus(1'b1, 4'b0000, 32'h44332211);
            step(4);
            tx_done_b = 1'b1;
            step(1);
            tx_done_b = 1'b0;
            checkOutput("b2b_txen_off", 32'(tx_en_b), 32'h0);
            checkOutput("b2b_busy_off", 32'(busy_b), 32'h0);
            if (k < 4)
                expectGrant(1'b1, 4'(1 << ((k + 1) % 4)), 8'(((k + 1) % 4 + 1) * 17));
        end
        step(1);
        checkOutput("b2b_stays_idle", 32'(tx_en_b), 32'h0);

        // Single grant, 1-Clk latency, then TxDone and a 16-tick gap.
        // A request raised during the gap must wait for IDLE.
        applyStimulus(1'b0, 4'b0001, 32'h000000A5);
        expectGrant(1'b0, 4'b0001, 8'hA5);
        step(1);
        checkOutput("t1_txen", 32'(tx_en_a), 32'h1);
        checkOutput("t1_txdata", 32'(tx_data_a), 32'hA5);
        checkOutput("t1_busy", 32'(busy_a), 32'h1);
        applyStimulus(1'b0, 4'b0000, 32'h000000A5);
        step(1);
        checkOutput("t1_ack_pulse_end", 32'(ack_a), 32'h0);
        tx_done_a = 1'b1;
        step(1);
        tx_done_a = 1'b0;
        checkOutput("t1_txen_off", 32'(tx_en_a), 32'h0);
        applyStimulus(1'b0, 4'b0010, 32'h00003C00);
        pulseTicks(15);
        checkOutput("t1_gap_busy", 32'(busy_a), 32'h1);
        checkOutput("t1_gap_no_grant", 32'(grant_a), 32'h0);
        pulseTicks(1);
        checkOutput("t1_gap_done", 32'(busy_a), 32'h0);
        expectGrant(1'b0, 4'b0010, 8'h3C);
        step(1);
        checkOutput("t6_gap_req_grant", 32'(grant_a), 32'h2);
        applyStimulus(1'b0, 4'b0000, 32'h0);
        finishFrameA("t6a");

        // Last=1 and Req=1001: wrap scan picks 3, then 0.
        applyStimulus(1'b0, 4'b1001, 32'hD30000D0);
        expectGrant(1'b0, 4'b1000, 8'hD3);
        step(1);
        checkOutput("t3_first", 32'(grant_a), 32'h8);
        applyStimulus(1'b0, 4'b0001, 32'hD30000D0);
        finishFrameA("t3a");
        expectGrant(1'b0, 4'b0001, 8'hD0);
        step(1);
        checkOutput("t3_second", 32'(grant_a), 32'h1);
        applyStimulus(1'b0, 4'b0000, 32'h0);
        finishFrameA("t3b");

        // Watchdog: no TxDone, abort after 200 ticks.
        applyStimulus(1'b0, 4'b0100, 32'h00770000);
        expectGrant(1'b0, 4'b0100, 8'h77);
        step(1);
        applyStimulus(1'b0, 4'b0000, 32'h0);
        pulseTicks(199);
        checkOutput("t4_still_send", 32'(tx_en_a), 32'h1);
        expectErrA();
        pulseTicks(1);
        checkOutput("t4_err", 32'(err_a), 32'h1);
        checkOutput("t4_txen_off", 32'(tx_en_a), 32'h0);
        checkOutput("t4_grant_off", 32'(grant_a), 32'h0);
        checkOutput("t4_gap_busy", 32'(busy_a), 32'h1);
        step(1);
        checkOutput("t4_err_pulse_end", 32'(err_a), 32'h0);
        pulseTicks(16);
        checkOutput("t4_idle", 32'(busy_a), 32'h0);
        applyStimulus(1'b0, 4'b1000, 32'h88000000);
        expectGrant(1'b0, 4'b1000, 8'h88);
        step(1);
        checkOutput("t4_recover", 32'(tx_en_a), 32'h1);
        applyStimulus(1'b0, 4'b0000, 32'h0);
        finishFrameA("t4b");

        // TxDone on the same cycle the timeout count is reached: no Err.
        applyStimulus(1'b0, 4'b0001, 32'h00000099);
        expectGrant(1'b0, 4'b0001, 8'h99);
        step(1);
        applyStimulus(1'b0, 4'b0000, 32'h0);
        pulseTicks(199);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        tx_done_a = 1'b1;
        step(1);
        tx_done_a = 1'b0;
        checkOutput("t6_no_err", 32'(err_a), 32'h0);
        checkOutput("t6_txen_off", 32'(tx_en_a), 32'h0);
        pulseTicks(16);
        checkOutput("t6_idle", 32'(busy_a), 32'h0);

        // Reset in the middle of SEND, then pointer restarts at 3.
        applyStimulus(1'b0, 4'b0100, 32'h005A0000);
        expectGrant(1'b0, 4'b0100, 8'h5A);
        step(1);
        checkOutput("t5_txdata", 32'(tx_data_a), 32'h5A);
        applyStimulus(1'b0, 4'b0000, 32'h0);
        step(2);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_txen", 32'(tx_en_a), 32'h0);
        checkOutput("t5_rst_grant", 32'(grant_a), 32'h0);
        checkOutput("t5_rst_txdata", 32'(tx_data_a), 32'h0);
        checkOutput("t5_rst_busy", 32'(busy_a), 32'h0);
        step(2);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'b1010, 32'hB300B100);
        expectGrant(1'b0, 4'b0010, 8'hB1);
        step(1);
        checkOutput("t5_after_rst", 32'(grant_a), 32'h2);
        applyStimulus(1'b0, 4'b0000, 32'h0);
        finishFrameA("t5b");

        step(2);
        checkOutput("queue_a_drained", 32'(q_a.size()), 32'h0);
        checkOutput("queue_b_drained", 32'(q_b.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NREQ byte-producing requesters using round-robin arbitration.
- Captures the granted requester's byte and drives TxData/TxEn into the transmitter.
- Waits for TxDone, then enforces a configurable inter-frame gap before the next grant.
- Contains a tick-based watchdog that aborts and flags an error if the transmitter never reports TxDone.
- Sits between application byte sources and the UART transmitter; it shares the baud Tick with the transmitter and receiver.

Parameters:
NREQ, 4, number of requesters (2..8)
GAP_TICKS, 16, idle Ticks inserted after each frame before the next grant (0 = no gap)
TIMEOUT_TICKS, 200, Ticks allowed in SEND without TxDone before abort (must exceed 16*(NBits+2))
CW, 16, width of the tick counter; must hold max(GAP_TICKS, TIMEOUT_TICKS)

Ports:
Clk  input  1  system clock
Rst_n  input  1  asynchronous active-low reset
Tick  input  1  baud oversample tick from the baud-rate generator, one Clk wide
Req  input  NREQ  per-requester byte-pending request, level
ReqData  input  8*NREQ  requester bytes; byte i is at bits [8i+7:8i]
Ack  output  NREQ  one-hot, one-Clk pulse: byte i accepted
Grant  output  NREQ  one-hot owner of the transmitter; held through SEND
TxData  output  8  byte to the UART transmitter
TxEn  output  1  transmitter enable; high only in SEND
TxDone  input  1  one-Clk pulse from the transmitter at end of stop bit
Busy  output  1  high in any state other than IDLE
Err  output  1  one-Clk pulse on watchdog abort

Behaviour:
- All outputs are registered.
- Reset (async, Rst_n=0):
  - state=IDLE; Ack=0, Grant=0, TxData=8'h00, TxEn=0, Busy=0, Err=0.
  - Tick counter=0; round-robin pointer Last=NREQ-1, so index 0 has first priority.
- Reset mid-SEND drops TxEn and Grant immediately. The partially sent frame is lost and no Ack is reissued.
- States: IDLE, SEND, GAP.
- IDLE:
  - If |Req, select the winner w: the first set bit scanning from (Last+1) mod NREQ upward with wrap.
  - At the next edge: TxData<=ReqData[w], Grant<=onehot(w), Ack<=onehot(w) for exactly one cycle, TxEn<=1, Busy<=1, Last<=w, counter<=0, state->SEND.
  - Latency from Req seen in IDLE to TxEn=1 is 1 Clk.
- Requester handshake: hold Req and ReqData stable until Ack, then drop Req or present the next byte. Req sampled high during SEND/GAP is ignored until IDLE.
- SEND:
  - TxData and Grant are held constant.
  - Counter increments on each Tick.
  - TxDone=1: next edge TxEn<=0, Grant<=0, counter<=0; state->GAP, or ->IDLE if GAP_TICKS=0.
  - Counter reaches TIMEOUT_TICKS without TxDone: same exit, plus Err pulse for one cycle.
  - TxDone and timeout in the same cycle: TxDone wins and no Err is raised.
- GAP:
  - Counter increments on Tick.
  - When the counter equals GAP_TICKS, next edge counter<=0, state->IDLE, Busy<=0.
  - TxEn stays 0 throughout.
- Back-to-back operation: with GAP_TICKS=0 a pending Req is granted 2 Clk after TxDone (one Clk for SEND->IDLE, one for IDLE->SEND).
- Fairness: once served, a requester cannot win again until every other asserted requester has been served.
- Single requester (only one Req bit set): it is granted every cycle it is eligible.
- Counter saturates at its terminal value and never wraps.
- Tick and TxDone in the same cycle: TxDone takes precedence and the Tick is not counted.

Test Plan:
1. Reset, then Req=4'b0001, ReqData[7:0]=8'hA5 -> next Clk: Ack=0001 pulse, Grant=0001, TxEn=1, TxData=A5. TxDone pulse -> TxEn=0. After 16 Ticks, Busy=0.
2. Req=4'b1111 held, bytes 11/22/33/44, TxDone returned 5 Clk after each grant, GAP_TICKS=0 -> grant order 0,1,2,3,0 with Ack matching each, 2 Clk between TxDone and next TxEn.
3. Last=1, Req=4'b1001 -> grant index 3 (wrap scan from 2), then index 0 on the next round.
4. TxDone never returned -> after 200 Ticks in SEND: Err pulses once, TxEn=0, Grant=0, GAP entered; next Req is served normally.
5. Rst_n asserted low mid-SEND with TxData=5A -> outputs immediately at reset values; after release, Req=0010 is granted index 1 first (Last reset to 3).
6. Req asserted during GAP -> no Ack until GAP completes. TxDone coincident with timeout terminal count -> no Err.
